// File: rtl/config_int_add_seg_gate_pkg.sv
// Shared helpers for the segment-gated adder: segment count, mode clamping,
// active-segment masks and parameter legality.
package config_add_pkg;

  localparam int unsigned MAX_SEGS = 32;

  function automatic int unsigned num_segs(input int unsigned dw, input int unsigned sw);
    return (sw == 0) ? 0 : dw / sw;
  endfunction

  function automatic bit params_ok(input int unsigned dw, input int unsigned sw,
                                   input int unsigned mw, input int unsigned cw);
    return (sw != 0) && ((dw % sw) == 0) && ((dw / sw) >= 2) &&
           ((dw / sw) <= MAX_SEGS) && (mw >= 1) && (cw >= 1);
  endfunction

  // Requested gated-segment count, limited so the top segment stays active.
  function automatic int unsigned clamp_mode(input int unsigned mode, input int unsigned nsegs);
    return (mode > nsegs - 1) ? nsegs - 1 : mode;
  endfunction

  // Bit k set iff segment k is active (k >= m).
  function automatic logic [MAX_SEGS-1:0] seg_mask(input int unsigned m);
    logic [MAX_SEGS-1:0] mask;
    mask = '0;
    for (int unsigned k = 0; k < MAX_SEGS; k++) begin
      mask[k] = (k >= m);
    end
    return mask;
  endfunction

endpackage

// File: rtl/config_int_add_seg_gate_slice.sv
// One adder segment; i_cin_kill breaks the carry chain at the lowest active segment.
module seg_add_slice #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_cin,
  input  logic         i_cin_kill,
  output logic [W-1:0] o_sum,
  output logic         o_cout
);

  logic w_cin;

  assign w_cin = i_cin & ~i_cin_kill;
  assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + (W+1)'(w_cin);

endmodule

// File: rtl/config_int_add_seg_gate.sv
// Two-stage valid/ready integer adder with per-beat low-segment gating and a
// saturating count of accepted beats.
module config_int_add_seg_gate
  import config_add_pkg::*;
#(
  parameter int unsigned DATA_PATH_BITWIDTH = 32,
  parameter int unsigned SEG_BITWIDTH       = 8,
  parameter int unsigned MODE_W             = 3,
  parameter int unsigned CNT_W              = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [MODE_W-1:0]             mode,
  input  logic [DATA_PATH_BITWIDTH-1:0] a,
  input  logic [DATA_PATH_BITWIDTH-1:0] b,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_PATH_BITWIDTH-1:0] c,
  output logic                          c_ovf,
  output logic [CNT_W-1:0]              op_count
);

  localparam int unsigned DW       = DATA_PATH_BITWIDTH;
  localparam int unsigned SW       = SEG_BITWIDTH;
  localparam int unsigned NUM_SEGS = num_segs(DATA_PATH_BITWIDTH, SEG_BITWIDTH);

  if (!params_ok(DATA_PATH_BITWIDTH, SEG_BITWIDTH, MODE_W, CNT_W)) begin : g_bad_params
    $error("config_int_add_seg_gate: illegal parameter combination");
  end

  logic                r_rst_reg;
  logic                r_s1_valid;
  logic [MODE_W-1:0]   r_s1_m;
  logic [DW-1:0]       r_a;
  logic [DW-1:0]       r_b;
  logic                r_s2_valid;
  logic [MODE_W-1:0]   r_s2_m;
  logic [DW-1:0]       r_c;
  logic                r_c_ovf;
  logic [CNT_W-1:0]    r_op_count;

  logic                w_accept;
  logic                w_s1_adv;
  logic [MODE_W-1:0]   w_m_in;
  logic [NUM_SEGS-1:0] w_act_in;
  logic [NUM_SEGS-1:0] w_act_s1;
  logic [NUM_SEGS-1:0] w_act_s2;
  logic [NUM_SEGS-1:0] w_kill;
  logic [NUM_SEGS:0]   w_carry;
  logic [DW-1:0]       w_sum;
  logic [DW-1:0]       w_c_mask;

  // Handshake: S1 drains into S2 when S2 is empty or being consumed.
  assign w_s1_adv = r_s1_valid && (!r_s2_valid || out_ready);
  assign in_ready = r_rst_reg && (!r_s1_valid || w_s1_adv);
  assign w_accept = in_valid && in_ready;

  assign w_m_in   = MODE_W'(clamp_mode(32'(mode), NUM_SEGS));
  assign w_act_in = NUM_SEGS'(seg_mask(32'(w_m_in)));
  assign w_act_s1 = NUM_SEGS'(seg_mask(32'(r_s1_m)));
  assign w_act_s2 = NUM_SEGS'(seg_mask(32'(r_s2_m)));

  // Internal reset copy: released one clock after rst deasserts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_rst_reg <= 1'b0;
    else      r_rst_reg <= 1'b1;
  end

  // S1: only active operand segments are enabled; gated ones hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_valid <= 1'b0;
      r_s1_m     <= '0;
      r_a        <= '0;
      r_b        <= '0;
    end else begin
      if (w_accept) begin
        r_s1_valid <= 1'b1;
        r_s1_m     <= w_m_in;
      end else if (w_s1_adv) begin
        r_s1_valid <= 1'b0;
      end
      for (int unsigned k = 0; k < NUM_SEGS; k++) begin
        if (w_accept && w_act_in[k]) begin
          r_a[k*SW +: SW] <= a[k*SW +: SW];
          r_b[k*SW +: SW] <= b[k*SW +: SW];
        end
      end
    end
  end

  assign w_carry[0] = 1'b0;

  for (genvar k = 0; k < NUM_SEGS; k++) begin : g_seg
    assign w_kill[k] = (32'(r_s1_m) == k);
    assign w_c_mask[k*SW +: SW] = {SW{w_act_s2[k]}};

    seg_add_slice #(.W(SW)) u_slice (
      .i_a       (r_a[k*SW +: SW]),
      .i_b       (r_b[k*SW +: SW]),
      .i_cin     (w_carry[k]),
      .i_cin_kill(w_kill[k]),
      .o_sum     (w_sum[k*SW +: SW]),
      .o_cout    (w_carry[k+1])
    );
  end

  // S2: result register, active segments only; holds while stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s2_valid <= 1'b0;
      r_s2_m     <= '0;
      r_c        <= '0;
      r_c_ovf    <= 1'b0;
    end else begin
      if (w_s1_adv) begin
        r_s2_valid <= 1'b1;
        r_s2_m     <= r_s1_m;
        r_c_ovf    <= w_carry[NUM_SEGS];
      end else if (out_ready) begin
        r_s2_valid <= 1'b0;
      end
      for (int unsigned k = 0; k < NUM_SEGS; k++) begin
        if (w_s1_adv && w_act_s1[k]) begin
          r_c[k*SW +: SW] <= w_sum[k*SW +: SW];
        end
      end
    end
  end

  // Saturating accepted-beat counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op_count <= '0;
    end else if (w_accept && (r_op_count != {CNT_W{1'b1}})) begin
      r_op_count <= r_op_count + CNT_W'(1);
    end
  end

  // Gated segments never expose stale held bits.
  assign c         = r_c & w_c_mask;
  assign c_ovf     = r_c_ovf;
  assign out_valid = r_s2_valid;
  assign op_count  = r_op_count;

endmodule
